npc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the NPC core datapath (PC register, decoder, ALU, register file).
- Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
- Runs valid/ready handshakes to the instruction-fetch and load/store ports.
- Gates PC update and register-file write enables so each fires exactly once per instruction.
- Halts on ebreak or a bus timeout.

---
 rtl/npc_pkg.sv | 36 +++
 rtl/npc_req_hs.sv | 47 ++++
 rtl/npc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_npc_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// ============================================================================
// Module   : npc_pkg
// Brief    : Shared states, opcodes and encodings for the NPC controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package npc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_t;

    localparam logic [6:0]  OP_LOAD     = 7'b0000011;
    localparam logic [6:0]  OP_STORE    = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic [31:0] NOP_INST    = 32'h00000013;
    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    function automatic logic inst_is_mem(input logic [31:0] i);
        return (i[6:0] == OP_LOAD) || (i[6:0] == OP_STORE);
    endfunction

    // Stores and branches have no rd field; rd == x0 is architecturally discarded.
    function automatic logic inst_writes_rd(input logic [31:0] i);
        return (i[6:0] != OP_STORE) && (i[6:0] != OP_BRANCH) && (i[11:7] != 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/npc_req_hs.sv
// ============================================================================
// Module   : npc_req_hs
// Brief    : One valid/ready request plus response wait, with bus timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module npc_req_hs #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic req_ready,
    input  logic rsp_valid,
    output logic req_valid,
    output logic done,
    output logic timeout
);

    localparam logic [15:0] c_LIMIT = 16'(TIMEOUT - 1);

    logic        r_hs_done;
    logic [15:0] r_cnt;
    logic        w_hs_now;
    logic        w_hs_seen;

    assign req_valid = active && !r_hs_done;
    assign w_hs_now  = req_valid && req_ready;
    assign w_hs_seen = r_hs_done || w_hs_now;
    assign done      = active && w_hs_seen && rsp_valid;
    // >= keeps the timeout armed if a late handshake pushed the count past the limit.
    assign timeout   = active && !done && !w_hs_now && (r_cnt >= c_LIMIT);

    always_ff @(posedge clk) begin
        if (rst || !active || done || timeout) begin
            r_hs_done <= 1'b0;
            r_cnt     <= 16'd0;
        end else begin
            r_hs_done <= w_hs_seen;
            r_cnt     <= r_cnt + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/npc_ctrl.sv
// ============================================================================
// Module   : npc_ctrl
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core.
//            NPC_CTRL_PERF_EN adds perf_cycle / perf_instret counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module npc_ctrl
    import npc_pkg::*;
#(
    parameter int          TIMEOUT = 256,
    parameter logic [31:0] EBREAK  = EBREAK_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_data,
    output logic [31:0] inst,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic        bus_err,
    output logic [2:0]  state
`ifdef NPC_CTRL_PERF_EN
    ,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
`endif
);

    ctrl_state_t r_state;
    logic [31:0] r_inst;
    logic        r_pc_wen;
    logic        r_rf_wen;
    logic        r_halt;
    logic        r_bus_err;

    logic w_ifu_done;
    logic w_ifu_tmo;
    logic w_lsu_done;
    logic w_lsu_tmo;

    npc_req_hs #(.TIMEOUT(TIMEOUT)) u_ifu_hs (
        .clk       (clk),
        .rst       (rst),
        .active    (r_state == ST_FETCH),
        .req_ready (ifu_req_ready),
        .rsp_valid (ifu_rsp_valid),
        .req_valid (ifu_req_valid),
        .done      (w_ifu_done),
        .timeout   (w_ifu_tmo)
    );

    npc_req_hs #(.TIMEOUT(TIMEOUT)) u_lsu_hs (
        .clk       (clk),
        .rst       (rst),
        .active    (r_state == ST_MEM),
        .req_ready (lsu_req_ready),
        .rsp_valid (lsu_rsp_valid),
        .req_valid (lsu_req_valid),
        .done      (w_lsu_done),
        .timeout   (w_lsu_tmo)
    );

    // Strobes are registered on the transition into WB so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_inst    <= NOP_INST;
            r_pc_wen  <= 1'b0;
            r_rf_wen  <= 1'b0;
            r_halt    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_pc_wen <= 1'b0;
            r_rf_wen <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (w_ifu_done) begin
                        r_inst  <= ifu_rsp_data;
                        r_state <= ST_DECODE;
                    end else if (w_ifu_tmo) begin
                        r_state   <= ST_HALT;
                        r_halt    <= 1'b1;
                        r_bus_err <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (r_inst == EBREAK) begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (inst_is_mem(r_inst)) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state  <= ST_WB;
                        r_pc_wen <= 1'b1;
                        r_rf_wen <= inst_writes_rd(r_inst);
                    end
                end
                ST_MEM: begin
                    if (w_lsu_done) begin
                        r_state  <= ST_WB;
                        r_pc_wen <= 1'b1;
                        r_rf_wen <= inst_writes_rd(r_inst);
                    end else if (w_lsu_tmo) begin
                        r_state   <= ST_HALT;
                        r_halt    <= 1'b1;
                        r_bus_err <= 1'b1;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign ifu_addr = pc;
    assign inst     = r_inst;
    assign pc_wen   = r_pc_wen;
    assign rf_wen   = r_rf_wen;
    assign halt     = r_halt;
    assign bus_err  = r_bus_err;
    assign state    = r_state;

`ifdef NPC_CTRL_PERF_EN
    logic [63:0] r_perf_cycle;
    logic [63:0] r_perf_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycle   <= 64'd0;
            r_perf_instret <= 64'd0;
        end else begin
            if (r_state != ST_HALT) begin
                r_perf_cycle <= r_perf_cycle + 64'd1;
            end
            if (r_pc_wen) begin
                r_perf_instret <= r_perf_instret + 64'd1;
            end
        end
    end

    assign perf_cycle   = r_perf_cycle;
    assign perf_instret = r_perf_instret;
`endif

endmodule

`default_nettype wire

// File: tb/tb_npc_ctrl.sv
// ============================================================================
// Module   : tb_npc_ctrl
// Brief    : Scoreboard bench for npc_ctrl with a random bus responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_npc_ctrl;

    localparam int          TMO    = 8;
    localparam logic [31:0] EBRK   = 32'h00100073;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_data  = 32'h0;
    logic [31:0] inst;
    logic        lsu_req_valid;
    logic        lsu_req_ready = 1'b0;
    logic        lsu_rsp_valid = 1'b0;
    logic        rf_wen;
    logic        pc_wen;
    logic        halt;
    logic        bus_err;
    logic [2:0]  state;

    npc_ctrl #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .inst          (inst),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_wen        (rf_wen),
        .pc_wen        (pc_wen),
        .halt          (halt),
        .bus_err       (bus_err),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Environment PC register, advanced by the controller's strobe.
    always @(posedge clk) begin
        if (rst) pc <= 32'h80000000;
        else if (pc_wen) pc <= pc + 32'd4;
    end

    typedef struct {
        bit          is_halt;
        logic [31:0] inst;
        bit          rf;
        bit          mem;
        bit          berr;
        int          cyc;
        int          ifu_vc;
        int          lsu_vc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t m_e;
    int   m_cyc = 0, m_ivc = 0, m_lvc = 0;
    bit   m_mem = 0, m_prev_halt = 0;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            m_cyc = 0; m_ivc = 0; m_lvc = 0; m_mem = 0; m_prev_halt = 0;
        end else begin
            m_cyc++;
            if (ifu_req_valid) begin
                m_ivc++;
                chk("ifu_addr", ifu_addr, pc);
            end
            if (lsu_req_valid) m_lvc++;
            if (state == 3'd3) m_mem = 1;
            if (rf_wen && !pc_wen) chk("rf_wen_alone", 1, 0);
            if (pc_wen || (halt && !m_prev_halt)) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_event", {pc_wen, halt}, 0);
                end else begin
                    m_e = sbq.pop_front();
                    chk("is_halt", halt, m_e.is_halt);
                    if (m_e.is_halt) begin
                        chk("bus_err", bus_err, m_e.berr);
                    end else begin
                        chk("inst", inst, m_e.inst);
                        chk("rf_wen", rf_wen, m_e.rf);
                        chk("mem_visit", m_mem, m_e.mem);
                        chk("lsu_valid_cycles", m_lvc, m_e.lsu_vc);
                    end
                    chk("latency", m_cyc, m_e.cyc);
                    chk("ifu_valid_cycles", m_ivc, m_e.ifu_vc);
                end
                m_cyc = 0; m_ivc = 0; m_lvc = 0; m_mem = 0;
            end
            if (halt) chk("halt_quiet", {ifu_req_valid, lsu_req_valid, pc_wen, rf_wen}, 0);
            m_prev_halt = halt;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_fetch(input int rdy, input int rsp, input logic [31:0] data);
        for (int c = 0; c <= rdy + rsp; c++) begin
            ifu_req_ready = (c == rdy);
            if (c < rdy) begin
                ifu_rsp_valid = 1'($urandom_range(0, 1));
                ifu_rsp_data  = $urandom;
            end else if (c == rdy + rsp) begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_data  = data;
            end else begin
                ifu_rsp_valid = 1'b0;
                ifu_rsp_data  = $urandom;
            end
            step();
        end
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
    endtask

    task automatic drive_lsu(input int rdy, input int rsp);
        for (int c = 0; c <= rdy + rsp; c++) begin
            lsu_req_ready = (c == rdy);
            if (c < rdy) lsu_rsp_valid = 1'($urandom_range(0, 1));
            else         lsu_rsp_valid = (c == rdy + rsp);
            step();
        end
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] i, input int rdy, input int rsp,
                             input int lrdy, input int lrsp);
        exp_t e;
        logic [6:0] op;
        bit mem;
        op  = i[6:0];
        mem = (op == 7'h03) || (op == 7'h23);
        e.is_halt = 0;
        e.inst    = i;
        e.rf      = (op != 7'h23) && (op != 7'h63) && (i[11:7] != 5'd0);
        e.mem     = mem;
        e.berr    = 0;
        e.cyc     = (rdy + rsp + 1) + 2 + (mem ? lrdy + lrsp + 1 : 0) + 1;
        e.ifu_vc  = rdy + 1;
        e.lsu_vc  = mem ? lrdy + 1 : 0;
        sbq.push_back(e);
        drive_fetch(rdy, rsp, i);
        step();
        step();
        if (mem) drive_lsu(lrdy, lrsp);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_state", state, 3'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_strobes", {pc_wen, rf_wen, halt, bus_err}, 0);
    endtask

    logic [6:0] ops [7] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6f};

    initial begin
        exp_t e;
        logic [31:0] r;
        step();
        do_reset();

        run_instr(32'h00500093, 0, 0, 0, 0);   // addi x1,x0,5
        run_instr(32'h00500093, 3, 2, 0, 0);   // slow fetch
        run_instr(32'h00102023, 0, 0, 0, 5);   // sw
        run_instr(32'h00002103, 1, 1, 2, 1);   // lw x2
        run_instr(32'h00100013, 0, 0, 0, 0);   // addi x0,x0,1
        run_instr(32'h00000063, 0, 1, 0, 0);   // beq
        run_instr(32'h00500093, 3, 4, 0, 0);   // response on the last legal cycle

        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            run_instr({r[31:7], ops[$urandom_range(0, 6)]},
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // ebreak: halt without error, no strobes while held
        e = '{is_halt: 1, inst: EBRK, rf: 0, mem: 0, berr: 0, cyc: 4, ifu_vc: 2, lsu_vc: 0};
        sbq.push_back(e);
        drive_fetch(1, 0, EBRK);
        step();
        repeat (20) step();
        chk("ebreak_state", state, 3'd5);
        do_reset();

        // fetch timeout: ready at once, response never arrives
        e = '{is_halt: 1, inst: 0, rf: 0, mem: 0, berr: 1, cyc: TMO + 1, ifu_vc: 1, lsu_vc: 0};
        sbq.push_back(e);
        for (int c = 0; c < TMO; c++) begin
            ifu_req_ready = (c == 0);
            step();
        end
        ifu_req_ready = 1'b0;
        chk("tmo_state", state, 3'd5);
        chk("tmo_bus_err", bus_err, 1);
        repeat (5) step();
        do_reset();

        run_instr(32'h00500093, 0, 0, 0, 0);

        // reset while a store request is outstanding
        drive_fetch(0, 0, 32'h00102023);
        step();
        step();
        step();
        chk("mid_mem_valid", lsu_req_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_state", state, 3'd0);
        chk("mid_rst_lsu_valid", lsu_req_valid, 0);
        chk("mid_rst_inst", inst, NOP);

        run_instr(32'h00002103, 0, 0, 0, 0);
        repeat (4) step();
        chk("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
